// File: rtl/tx_unit_fifo_if.sv
// ---------------------------------------------------------------------------
// tx_unit_fifo_if : bus-side and serial-side signals of the UART transmit unit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tx_unit_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 3
);
  logic [DATA_BITS-1:0] d_in;
  logic                 load;
  logic                 en_tx;
  logic [1:0]           parity_mode;
  logic                 stop2;
  logic                 txd;
  logic                 ts;
  logic                 full;
  logic                 ovf;
  logic [CNT_W-1:0]     fifo_cnt;

  modport master (
    output d_in, load, en_tx, parity_mode, stop2,
    input  txd, ts, full, ovf, fifo_cnt
  );

  modport slave (
    input  d_in, load, en_tx, parity_mode, stop2,
    output txd, ts, full, ovf, fifo_cnt
  );
endinterface

`default_nettype wire

// File: rtl/tx_unit_fifo.sv
// ---------------------------------------------------------------------------
// tx_unit_fifo : FIFO-buffered UART transmitter, LSB-first, optional parity
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tx_unit_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic          clk,
  input  logic          rst,
  tx_unit_fifo_if.slave bus
);

  localparam int         c_PTR_W    = $clog2(FIFO_DEPTH);
  localparam int         c_BC_W     = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [1:0] c_PAR_EVEN = 2'b01;
  localparam logic [1:0] c_PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 txd_q, txd_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [c_BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]           pmode_q, pmode_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_cnt_q, stop_cnt_d;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   wptr_q, rptr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_full;
  logic                 w_nonempty;
  logic                 w_par_en;
  logic                 w_par_bit;
  logic [c_BC_W-1:0]    w_bit_nxt;

  assign w_full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign w_nonempty = (cnt_q != '0);
  // A pop frees a slot in the same cycle, so a load is accepted even when full.
  assign w_push     = bus.load && (!w_full || w_pop);
  assign w_par_en   = (pmode_q == c_PAR_EVEN) || (pmode_q == c_PAR_ODD);
  assign w_par_bit  = (pmode_q == c_PAR_ODD) ? ~^data_q : ^data_q;
  assign w_bit_nxt  = bit_cnt_q + c_BC_W'(1);

  always_comb begin
    state_d    = state_q;
    txd_d      = txd_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    pmode_d    = pmode_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    w_pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.en_tx && w_nonempty) w_pop = 1'b1;
      end
      S_START: begin
        if (bus.en_tx) begin
          txd_d     = data_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.en_tx) begin
          if (bit_cnt_q == c_BC_W'(DATA_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            if (w_par_en) begin
              txd_d   = w_par_bit;
              state_d = S_PARITY;
            end else begin
              txd_d   = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_cnt_d = w_bit_nxt;
            txd_d     = data_q[w_bit_nxt];
          end
        end
      end
      S_PARITY: begin
        if (bus.en_tx) begin
          txd_d      = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
      end
      S_STOP: begin
        if (bus.en_tx) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (w_nonempty) begin
            w_pop = 1'b1;
          end else begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        txd_d   = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Frame start: format inputs are captured here and held for the whole frame.
    if (w_pop) begin
      data_d  = mem_q[rptr_q];
      pmode_d = bus.parity_mode;
      stop2_d = bus.stop2;
      txd_d   = 1'b0;
      state_d = S_START;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      txd_q      <= 1'b1;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      pmode_q    <= 2'b00;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      txd_q      <= txd_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
      if (w_push) wptr_q <= wptr_q + c_PTR_W'(1);
      if (w_pop)  rptr_q <= rptr_q + c_PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= bus.d_in;
  end

  assign bus.txd      = txd_q;
  assign bus.ts       = (state_q == S_IDLE) && !w_nonempty;
  assign bus.full     = w_full;
  assign bus.ovf      = bus.load && w_full && !w_pop;
  assign bus.fifo_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_unit_fifo.sv
// ---------------------------------------------------------------------------
// tb_tx_unit_fifo : directed self-checking bench for tx_unit_fifo (8- and 5-bit builds)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tx_unit_fifo;

  logic clk;
  logic rst;
  logic tick;
  int   n_checks;
  int   n_fail;

  tx_unit_fifo_if #(.DATA_BITS(8), .CNT_W(3)) bus8 ();
  tx_unit_fifo_if #(.DATA_BITS(5), .CNT_W(3)) bus5 ();

  assign bus8.en_tx = tick;
  assign bus5.en_tx = tick;

  tx_unit_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .CNT_W(3)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  tx_unit_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4), .CNT_W(3)) dut5 (
    .clk (clk),
    .rst (rst),
    .bus (bus5)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud tick: one-cycle pulse every 16 clocks.
  initial begin
    tick = 1'b0;
    forever begin
      repeat (15) @(posedge clk);
      #1 tick = 1'b1;
      @(posedge clk);
      #1 tick = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns on the posedge where the tick is sampled high.
  task automatic wait_tick();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (tick) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_tick: no baud tick within 40 cycles");
  endtask

  // Waits for a start bit, then samples txd mid-bit for every char of exp.
  task automatic check_bits(input string exp, input bit sel5, input string name);
    bit   found;
    logic v;
    found = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      v = sel5 ? bus5.txd : bus8.txd;
      if (v === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s start: txd never went low within 80 cycles", name);
      return;
    end
    repeat (7) @(negedge clk);
    for (int k = 0; k < exp.len(); k++) begin
      v = sel5 ? bus5.txd : bus8.txd;
      n_checks++;
      if (v !== ((exp[k] == "1") ? 1'b1 : 1'b0)) begin
        n_fail++;
        $display("FAIL %s bit %0d: txd=%b required %c", name, k, v, exp[k]);
      end
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (bus8.txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b required 1", bus8.txd); end
    n_checks++;
    if (bus8.ts !== 1'b1) begin n_fail++; $display("FAIL reset_ts: got %b required 1", bus8.ts); end
    n_checks++;
    if (bus8.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b required 0", bus8.full); end
    n_checks++;
    if (bus8.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", bus8.ovf); end
    n_checks++;
    if (bus8.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", bus8.fifo_cnt); end
    n_checks++;
    if (bus5.txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd5: got %b required 1", bus5.txd); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_8n1();
    wait_tick();
    #1 bus8.d_in = 8'hA5;
    bus8.load = 1'b1;
    @(posedge clk);
    #1 bus8.load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus8.ts !== 1'b0) begin n_fail++; $display("FAIL 8n1_ts_after_load: got %b required 0", bus8.ts); end
    n_checks++;
    if (bus8.fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL 8n1_cnt_after_load: got %0d required 1", bus8.fifo_cnt); end
    check_bits("0101001011", 1'b0, "8N1_A5");
    n_checks++;
    if (bus8.ts !== 1'b1) begin n_fail++; $display("FAIL 8n1_ts_end: got %b required 1", bus8.ts); end
  endtask

  task automatic test_parity();
    bus8.parity_mode = 2'b01;
    bus8.stop2 = 1'b1;
    wait_tick();
    #1 bus8.d_in = 8'h07;
    bus8.load = 1'b1;
    @(posedge clk);
    #1 bus8.load = 1'b0;
    check_bits("011100000111", 1'b0, "8E2_07");
    n_checks++;
    if (bus8.ts !== 1'b1) begin n_fail++; $display("FAIL 8e2_ts_end: got %b required 1", bus8.ts); end

    bus8.parity_mode = 2'b10;
    bus8.stop2 = 1'b0;
    wait_tick();
    #1 bus8.d_in = 8'h07;
    bus8.load = 1'b1;
    @(posedge clk);
    #1 bus8.load = 1'b0;
    check_bits("01110000001", 1'b0, "8O1_07");

    bus5.parity_mode = 2'b01;
    bus5.stop2 = 1'b0;
    wait_tick();
    #1 bus5.d_in = 5'h1F;
    bus5.load = 1'b1;
    @(posedge clk);
    #1 bus5.load = 1'b0;
    check_bits("01111111", 1'b1, "5E1_1F");
    n_checks++;
    if (bus5.ts !== 1'b1) begin n_fail++; $display("FAIL 5e1_ts_end: got %b required 1", bus5.ts); end

    bus8.parity_mode = 2'b00;
    bus8.stop2 = 1'b0;
  endtask

  task automatic test_overflow_back_to_back();
    logic [7:0] bytes [5];
    bytes[0] = 8'h01; bytes[1] = 8'h80; bytes[2] = 8'h3C; bytes[3] = 8'hFF; bytes[4] = 8'h55;
    wait_tick();
    #1;
    for (int i = 0; i < 5; i++) begin
      bus8.d_in = bytes[i];
      bus8.load = 1'b1;
      @(negedge clk);
      if (i == 4) begin
        n_checks++;
        if (bus8.full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b required 1", bus8.full); end
        n_checks++;
        if (bus8.fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt: got %0d required 4", bus8.fifo_cnt); end
        n_checks++;
        if (bus8.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse: got %b required 1", bus8.ovf); end
      end
      @(posedge clk);
      #1;
    end
    bus8.load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus8.ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b required 0", bus8.ovf); end
    n_checks++;
    if (bus8.fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL ovf_cnt_hold: got %0d required 4", bus8.fifo_cnt); end
    check_bits("0100000001000000001100011110010111111111", 1'b0, "B2B_4");
    n_checks++;
    if (bus8.ts !== 1'b1) begin n_fail++; $display("FAIL b2b_ts_end: got %b required 1", bus8.ts); end
    repeat (40) @(negedge clk);
    n_checks++;
    if (bus8.txd !== 1'b1) begin n_fail++; $display("FAIL dropped_byte_sent: txd=%b required 1", bus8.txd); end
    n_checks++;
    if (bus8.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL b2b_cnt_end: got %0d required 0", bus8.fifo_cnt); end
  endtask

  task automatic test_full_pop();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33; bytes[3] = 8'h44;
    wait_tick();
    #1;
    for (int i = 0; i < 4; i++) begin
      bus8.d_in = bytes[i];
      bus8.load = 1'b1;
      @(posedge clk);
      #1;
    end
    bus8.load = 1'b0;
    wait_tick();
    #1 bus8.d_in = 8'h55;
    bus8.load = 1'b1;
    @(posedge clk);
    #1 bus8.load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus8.fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL fp_refill_cnt: got %0d required 4", bus8.fifo_cnt); end
    for (int i = 0; i < 9; i++) wait_tick();
    repeat (15) @(posedge clk);
    #1 bus8.d_in = 8'h66;
    bus8.load = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus8.ovf !== 1'b0) begin n_fail++; $display("FAIL fp_ovf: got %b required 0", bus8.ovf); end
    n_checks++;
    if (bus8.full !== 1'b1) begin n_fail++; $display("FAIL fp_full_before: got %b required 1", bus8.full); end
    @(posedge clk);
    #1 bus8.load = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus8.fifo_cnt !== 3'd4) begin n_fail++; $display("FAIL fp_cnt_after: got %0d required 4", bus8.fifo_cnt); end
    n_checks++;
    if (bus8.txd !== 1'b0) begin n_fail++; $display("FAIL fp_start: txd=%b required 0", bus8.txd); end
    check_bits("00100010010110011001000100010101010101010011001101", 1'b0, "FP_5");
    n_checks++;
    if (bus8.ts !== 1'b1) begin n_fail++; $display("FAIL fp_ts_end: got %b required 1", bus8.ts); end
  endtask

  task automatic test_reset_midframe();
    wait_tick();
    #1 bus8.d_in = 8'hA5;
    bus8.load = 1'b1;
    @(posedge clk);
    #1 bus8.d_in = 8'h3C;
    @(posedge clk);
    #1 bus8.load = 1'b0;
    for (int i = 0; i < 5; i++) wait_tick();
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus8.txd !== 1'b0) begin n_fail++; $display("FAIL rst_pre_bit3: txd=%b required 0", bus8.txd); end
    n_checks++;
    if (bus8.fifo_cnt !== 3'd1) begin n_fail++; $display("FAIL rst_pre_cnt: got %0d required 1", bus8.fifo_cnt); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus8.txd !== 1'b1) begin n_fail++; $display("FAIL rst_async_txd: got %b required 1", bus8.txd); end
    n_checks++;
    if (bus8.fifo_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_async_cnt: got %0d required 0", bus8.fifo_cnt); end
    n_checks++;
    if (bus8.ts !== 1'b1) begin n_fail++; $display("FAIL rst_async_ts: got %b required 1", bus8.ts); end
    @(posedge clk);
    #1 rst = 1'b0;
    wait_tick();
    #1 bus8.d_in = 8'hC3;
    bus8.load = 1'b1;
    @(posedge clk);
    #1 bus8.load = 1'b0;
    check_bits("0110000111", 1'b0, "RST_NEXT_C3");
    n_checks++;
    if (bus8.ts !== 1'b1) begin n_fail++; $display("FAIL rst_next_ts: got %b required 1", bus8.ts); end
  endtask

  task automatic test_mode_latch();
    bus8.parity_mode = 2'b01;
    bus8.stop2 = 1'b1;
    wait_tick();
    #1 bus8.d_in = 8'h07;
    bus8.load = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus8.load = 1'b0;
    wait_tick();
    repeat (3) @(posedge clk);
    #1 bus8.parity_mode = 2'b10;
    bus8.stop2 = 1'b0;
    check_bits("01110000011101110000001", 1'b0, "LATCH_E2_O1");
    n_checks++;
    if (bus8.ts !== 1'b1) begin n_fail++; $display("FAIL latch_ts_end: got %b required 1", bus8.ts); end
    bus8.parity_mode = 2'b00;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    bus8.d_in = '0;
    bus8.load = 1'b0;
    bus8.parity_mode = 2'b00;
    bus8.stop2 = 1'b0;
    bus5.d_in = '0;
    bus5.load = 1'b0;
    bus5.parity_mode = 2'b00;
    bus5.stop2 = 1'b0;

    test_reset();
    test_8n1();
    test_parity();
    test_overflow_back_to_back();
    test_full_pop();
    test_reset_midframe();
    test_mode_latch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
